// File: rtl/product_acc_pkg.sv
// Shared types and constants for the product accumulator.
package product_acc_pkg;

    localparam int unsigned DATA_W       = 32;
    localparam int unsigned DEFAULT_TAPS = 4;

    localparam logic [DATA_W-1:0] ACC_MAX = 32'h7FFF_FFFF;
    localparam logic [DATA_W-1:0] ACC_MIN = 32'h8000_0000;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

endpackage : product_acc_pkg

// File: rtl/sm_to_twos.sv
// Sign-magnitude to two's-complement conversion, saturating to the 32-bit range.
module sm_to_twos
    import product_acc_pkg::*;
(
    input  logic [DATA_W-1:0] mag,
    input  logic              sign,
    output logic [DATA_W-1:0] operand_c,
    output logic              ovf_c
);

    // Negate or pass through, clamping magnitudes that do not fit.
    always_comb begin
        operand_c = mag;
        ovf_c     = 1'b0;
        if (sign) begin
            if (mag > ACC_MIN) begin
                operand_c = ACC_MIN;
                ovf_c     = 1'b1;
            end else begin
                // -0 stays 0; -2^31 maps onto ACC_MIN exactly.
                operand_c = DATA_W'(-mag);
            end
        end else if (mag > ACC_MAX) begin
            operand_c = ACC_MAX;
            ovf_c     = 1'b1;
        end
    end

endmodule : sm_to_twos

// File: rtl/product_accumulator.sv
// Sums TAPS signed products into one saturating sample on a valid/ready port.
module product_accumulator
    import product_acc_pkg::*;
#(
    parameter int unsigned TAPS  = DEFAULT_TAPS,
    parameter int unsigned CNT_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] prod_mag,
    input  logic              prod_sign,
    input  logic              prod_ovf,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] acc_out,
    output logic              acc_ovf
);

    state_t             state, state_d;
    logic [DATA_W-1:0]  acc, acc_d;
    logic [CNT_W-1:0]   count, count_d;
    logic               sticky, sticky_d;
    logic [DATA_W-1:0]  acc_out_d;
    logic               acc_ovf_d;
    logic               out_valid_d;
    logic               in_ready_d;

    logic [DATA_W-1:0]  operand_c;
    logic               conv_ovf_c;
    logic [DATA_W:0]    sum_c;
    logic [DATA_W-1:0]  sat_sum_c;
    logic               sat_c;
    logic               accept_c;
    logic               last_c;

    sm_to_twos u_conv (
        .mag       (prod_mag),
        .sign      (prod_sign),
        .operand_c (operand_c),
        .ovf_c     (conv_ovf_c)
    );

    // Sign-extended add with clamp on signed overflow.
    always_comb begin
        sum_c     = {acc[DATA_W-1], acc} + {operand_c[DATA_W-1], operand_c};
        sat_sum_c = sum_c[DATA_W-1:0];
        sat_c     = 1'b0;
        if (sum_c[DATA_W:DATA_W-1] == 2'b01) begin
            sat_sum_c = ACC_MAX;
            sat_c     = 1'b1;
        end else if (sum_c[DATA_W:DATA_W-1] == 2'b10) begin
            sat_sum_c = ACC_MIN;
            sat_c     = 1'b1;
        end
    end

    assign accept_c = in_valid & in_ready;
    assign last_c   = (count == CNT_W'(TAPS - 1));

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state;
        acc_d       = acc;
        count_d     = count;
        sticky_d    = sticky;
        acc_out_d   = acc_out;
        acc_ovf_d   = acc_ovf;
        out_valid_d = out_valid;
        in_ready_d  = in_ready;
        unique case (state)
            ACCUM: begin
                if (accept_c) begin
                    if (last_c) begin
                        acc_out_d   = sat_sum_c;
                        acc_ovf_d   = sticky | prod_ovf | conv_ovf_c | sat_c;
                        acc_d       = '0;
                        count_d     = '0;
                        sticky_d    = 1'b0;
                        out_valid_d = 1'b1;
                        in_ready_d  = 1'b0;
                        state_d     = HOLD;
                    end else begin
                        acc_d    = sat_sum_c;
                        count_d  = count + CNT_W'(1);
                        sticky_d = sticky | prod_ovf | conv_ovf_c | sat_c;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = ACCUM;
                end
            end
            default: begin
                state_d = ACCUM;
            end
        endcase
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ACCUM;
            acc       <= '0;
            count     <= '0;
            sticky    <= 1'b0;
            acc_out   <= '0;
            acc_ovf   <= 1'b0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            state     <= state_d;
            acc       <= acc_d;
            count     <= count_d;
            sticky    <= sticky_d;
            acc_out   <= acc_out_d;
            acc_ovf   <= acc_ovf_d;
            out_valid <= out_valid_d;
            in_ready  <= in_ready_d;
        end
    end

endmodule : product_accumulator

// File: tb/tb_product_accumulator.sv
// Directed self-checking bench for product_accumulator (TAPS = 4).
module tb_product_accumulator;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] prod_mag;
    logic        prod_sign;
    logic        prod_ovf;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] acc_out;
    logic        acc_ovf;

    int checks   = 0;
    int failures = 0;

    product_accumulator #(.TAPS(4), .CNT_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .prod_mag  (prod_mag),
        .prod_sign (prod_sign),
        .prod_ovf  (prod_ovf),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .acc_out   (acc_out),
        .acc_ovf   (acc_ovf)
    );

    always #5 clk = ~clk;

    // Compare one observed value against its expected value.
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one product for exactly one edge.
    task automatic send(input logic [31:0] mag, input logic sign, input logic ovf);
        in_valid  = 1'b1;
        prod_mag  = mag;
        prod_sign = sign;
        prod_ovf  = ovf;
        tick();
        in_valid  = 1'b0;
        prod_ovf  = 1'b0;
    endtask

    // Take the held sample and confirm the return to ACCUM.
    task automatic take(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_ov_after"}, 32'(out_valid), 32'd0);
        check({tag, "_ir_after"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        prod_mag  = '0;
        prod_sign = 1'b0;
        prod_ovf  = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_acc_out", acc_out, 32'd0);
        check("rst_acc_ovf", 32'(acc_ovf), 32'd0);

        // Basic mixed-sign sample: 3 + 5 - 2 + 10 = 16.
        send(32'd3, 1'b0, 1'b0);
        send(32'd5, 1'b0, 1'b0);
        send(32'd2, 1'b1, 1'b0);
        check("basic_no_early_valid", 32'(out_valid), 32'd0);
        send(32'd10, 1'b0, 1'b0);
        check("basic_valid", 32'(out_valid), 32'd1);
        check("basic_acc", acc_out, 32'd16);
        check("basic_ovf", 32'(acc_ovf), 32'd0);
        check("basic_in_ready", 32'(in_ready), 32'd0);
        tick();
        check("basic_hold_valid", 32'(out_valid), 32'd1);
        check("basic_hold_ready", 32'(in_ready), 32'd0);
        take("basic");

        // Multiplier overflow flag at tap 2 is sticky for this sample only.
        send(32'd1, 1'b0, 1'b0);
        send(32'd1, 1'b0, 1'b1);
        send(32'd1, 1'b0, 1'b0);
        send(32'd1, 1'b0, 1'b0);
        check("povf_acc", acc_out, 32'd4);
        check("povf_ovf", 32'(acc_ovf), 32'd1);
        take("povf");
        repeat (4) send(32'd1, 1'b0, 1'b0);
        check("clr_acc", acc_out, 32'd4);
        check("clr_ovf", 32'(acc_ovf), 32'd0);
        take("clr");

        // Positive saturation of the running sum.
        send(32'h7FFF_FFF0, 1'b0, 1'b0);
        send(32'h0000_0020, 1'b0, 1'b0);
        send(32'd0, 1'b0, 1'b0);
        send(32'd0, 1'b0, 1'b0);
        check("psat_acc", acc_out, 32'h7FFF_FFFF);
        check("psat_ovf", 32'(acc_ovf), 32'd1);
        take("psat");

        // Negative saturation: -2^31 converts exactly, then -1 saturates.
        send(32'h8000_0000, 1'b1, 1'b0);
        send(32'd1, 1'b1, 1'b0);
        send(32'd0, 1'b0, 1'b0);
        send(32'd0, 1'b0, 1'b0);
        check("nsat_acc", acc_out, 32'h8000_0000);
        check("nsat_ovf", 32'(acc_ovf), 32'd1);
        take("nsat");

        // Exact -2^31 alone is not an overflow.
        send(32'h8000_0000, 1'b1, 1'b0);
        repeat (3) send(32'd0, 1'b0, 1'b0);
        check("nmin_acc", acc_out, 32'h8000_0000);
        check("nmin_ovf", 32'(acc_ovf), 32'd0);
        take("nmin");

        // Conversion clamp on an oversize positive magnitude.
        send(32'h9000_0000, 1'b0, 1'b0);
        repeat (3) send(32'd0, 1'b0, 1'b0);
        check("pconv_acc", acc_out, 32'h7FFF_FFFF);
        check("pconv_ovf", 32'(acc_ovf), 32'd1);
        take("pconv");

        // Conversion clamp on an oversize negative magnitude.
        send(32'h8000_0001, 1'b1, 1'b0);
        repeat (3) send(32'd0, 1'b0, 1'b0);
        check("nconv_acc", acc_out, 32'h8000_0000);
        check("nconv_ovf", 32'(acc_ovf), 32'd1);
        take("nconv");

        // Backpressure: held sample stays put, offered product is not taken.
        repeat (4) send(32'd2, 1'b0, 1'b0);
        check("bp_acc", acc_out, 32'd8);
        in_valid  = 1'b1;
        prod_mag  = 32'd7;
        prod_sign = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_acc_stable", acc_out, 32'd8);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_rel_ready", 32'(in_ready), 32'd1);
        check("bp_rel_valid", 32'(out_valid), 32'd0);
        check("bp_acc_kept", acc_out, 32'd8);
        tick();
        in_valid = 1'b0;
        repeat (3) send(32'd7, 1'b0, 1'b0);
        check("bp_next_valid", 32'(out_valid), 32'd1);
        check("bp_next_acc", acc_out, 32'd28);
        take("bp");

        // Reset mid-sample discards the partial sum and tap count.
        send(32'd100, 1'b0, 1'b0);
        send(32'd100, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mrst_valid", 32'(out_valid), 32'd0);
        check("mrst_ready", 32'(in_ready), 32'd1);
        check("mrst_acc_out", acc_out, 32'd0);
        repeat (2) send(32'd1, 1'b0, 1'b0);
        check("mrst_no_stale_2", 32'(out_valid), 32'd0);
        send(32'd1, 1'b0, 1'b0);
        check("mrst_no_stale_3", 32'(out_valid), 32'd0);
        send(32'd1, 1'b0, 1'b0);
        check("mrst_valid4", 32'(out_valid), 32'd1);
        check("mrst_acc", acc_out, 32'd4);
        check("mrst_ovf", 32'(acc_ovf), 32'd0);
        take("mrst");

        // Negative zero contributes nothing and raises no overflow.
        repeat (4) send(32'd0, 1'b1, 1'b0);
        check("nz_valid", 32'(out_valid), 32'd1);
        check("nz_acc", acc_out, 32'd0);
        check("nz_ovf", 32'(acc_ovf), 32'd0);
        take("nz");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_product_accumulator
